// File: rtl/qspi_sram_responder.sv
// Quad-SPI SRAM responder: decodes cs_n/sck/sio into byte reads/writes on a synchronous memory port.
// Latency: 2-flop input sync; mem_we 1 clk after detected 2nd-nibble rise; read nibble 1 clk after detected sck fall.
// Backpressure: none; the master paces everything via sck, the memory must answer exactly 1 clk after mem_re.
//
// Ports:
//   clk, reset_n            system clock (oversamples sck), async active-low reset
//   sram_cs_n, sram_sck     chip select and SPI-mode-0 serial clock from the master
//   sram_sio_i/o, _oe       SIO nibble in, SIO nibble out, output enable
//   mem_addr/wdata/we/re    backing-memory request port; mem_rdata valid 1 clk after mem_re
//   quad_mode               1 while SQI mode is active
module qspi_sram_responder #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sram_cs_n,
    input  logic                  sram_sck,
    input  logic [3:0]            sram_sio_i,
    output logic [3:0]            sram_sio_o,
    output logic                  sram_sio_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [7:0]            mem_rdata,
    output logic                  quad_mode
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_DUMMY  = 3'd3;
    localparam logic [2:0] S_WDATA  = 3'd4;
    localparam logic [2:0] S_RDATA  = 3'd5;
    localparam logic [2:0] S_IGNORE = 3'd6;

    // input synchronizers and edge-detect history
    logic [1:0] cs_sync;
    logic [1:0] sck_sync;
    logic [3:0] sio_meta;
    logic [3:0] sio_s;
    logic       cs_prev;
    logic       sck_prev;

    logic cs_s;
    logic sck_s;
    logic sck_rise;
    logic sck_fall;
    logic cs_rise;

    assign cs_s     = cs_sync[1];
    assign sck_s    = sck_sync[1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_rise  = cs_s & ~cs_prev;

    // protocol state
    logic [2:0]            state;
    logic [2:0]            cnt;
    logic [6:0]            cmd_sr;
    logic [ADDR_WIDTH-1:0] addr_sr;
    logic [3:0]            wr_sr;
    logic [3:0]            out_sr;
    logic                  nib_sel;
    logic                  is_read;
    logic                  re_d;
    logic [7:0]            hold;

    // command byte as it will look once the current rise is shifted in
    logic [7:0]            cmd_byte;
    logic                  cmd_done;
    logic [ADDR_WIDTH-1:0] addr_next;

    always_comb begin
        cmd_byte = quad_mode ? {cmd_sr[3:0], sio_s} : {cmd_sr, sio_s[0]};
        cmd_done = quad_mode ? (cnt == 3'd1) : (cnt == 3'd7);
        // only the low ADDR_WIDTH bits of the 24-bit address survive the shift
        addr_next = {addr_sr[ADDR_WIDTH-5:0], sio_s};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync     <= 2'b11;
            sck_sync    <= 2'b00;
            sio_meta    <= 4'h0;
            sio_s       <= 4'h0;
            cs_prev     <= 1'b1;
            sck_prev    <= 1'b0;
            state       <= S_IDLE;
            cnt         <= 3'd0;
            cmd_sr      <= 7'd0;
            addr_sr     <= '0;
            wr_sr       <= 4'h0;
            out_sr      <= 4'h0;
            nib_sel     <= 1'b0;
            is_read     <= 1'b0;
            re_d        <= 1'b0;
            hold        <= 8'h00;
            sram_sio_o  <= 4'h0;
            sram_sio_oe <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 8'h00;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            quad_mode   <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[0], sram_cs_n};
            sck_sync <= {sck_sync[0], sram_sck};
            sio_meta <= sram_sio_i;
            sio_s    <= sio_meta;
            cs_prev  <= cs_s;
            sck_prev <= sck_s;

            mem_we <= 1'b0;
            mem_re <= 1'b0;

            // memory answers one clk after the strobe
            re_d <= mem_re;
            if (re_d) begin
                hold <= mem_rdata;
            end

            // post-increment after each write strobe
            if (mem_we) begin
                mem_addr <= mem_addr + ADDR_WIDTH'(1);
            end

            if (cs_rise) begin
                state       <= S_IDLE;
                cnt         <= 3'd0;
                nib_sel     <= 1'b0;
                sram_sio_oe <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!cs_s) begin
                            state <= S_CMD;
                            cnt   <= 3'd0;
                        end
                    end
                    S_CMD: begin
                        if (sck_rise) begin
                            cmd_sr <= cmd_byte[6:0];
                            cnt    <= cnt + 3'd1;
                            if (cmd_done) begin
                                cnt   <= 3'd0;
                                state <= S_IGNORE;
                                if (!quad_mode && cmd_byte == 8'h38) begin
                                    quad_mode <= 1'b1;
                                end else if (quad_mode && cmd_byte == 8'hFF) begin
                                    quad_mode <= 1'b0;
                                end else if (quad_mode && cmd_byte == 8'h02) begin
                                    is_read <= 1'b0;
                                    state   <= S_ADDR;
                                end else if (quad_mode && cmd_byte == 8'h03) begin
                                    is_read <= 1'b1;
                                    state   <= S_ADDR;
                                end
                            end
                        end
                    end
                    S_ADDR: begin
                        if (sck_rise) begin
                            addr_sr <= addr_next;
                            cnt     <= cnt + 3'd1;
                            if (cnt == 3'd5) begin
                                cnt      <= 3'd0;
                                nib_sel  <= 1'b0;
                                mem_addr <= addr_next;
                                if (is_read) begin
                                    // first byte fetched during the dummy cycles
                                    mem_re <= 1'b1;
                                    state  <= S_DUMMY;
                                end else begin
                                    state <= S_WDATA;
                                end
                            end
                        end
                    end
                    S_DUMMY: begin
                        if (sck_rise) begin
                            cnt <= cnt + 3'd1;
                            if (cnt == 3'd1) begin
                                cnt     <= 3'd0;
                                nib_sel <= 1'b0;
                                state   <= S_RDATA;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (sck_rise) begin
                            wr_sr   <= sio_s;
                            nib_sel <= ~nib_sel;
                            if (nib_sel) begin
                                mem_we    <= 1'b1;
                                mem_wdata <= {wr_sr, sio_s};
                            end
                        end
                    end
                    S_RDATA: begin
                        if (sck_fall) begin
                            sram_sio_oe <= 1'b1;
                            if (!nib_sel) begin
                                // byte boundary: emit high nibble, keep low, prefetch next byte
                                sram_sio_o <= hold[7:4];
                                out_sr     <= hold[3:0];
                                mem_addr   <= mem_addr + ADDR_WIDTH'(1);
                                mem_re     <= 1'b1;
                                nib_sel    <= 1'b1;
                            end else begin
                                sram_sio_o <= out_sr;
                                nib_sel    <= 1'b0;
                            end
                        end
                    end
                    S_IGNORE: begin
                        // wait for cs_n to rise
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_sram_responder.sv
module tb_qspi_sram_responder;

    localparam int AW = 17;
    localparam int H  = 6;   // sck half period in clk cycles

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sram_cs_n = 1'b1;
    logic          sram_sck = 1'b0;
    logic [3:0]    sram_sio_i = 4'h0;
    logic [3:0]    sram_sio_o;
    logic          sram_sio_oe;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [7:0]    mem_rdata = 8'h00;
    logic          quad_mode;

    qspi_sram_responder #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sram_cs_n  (sram_cs_n),
        .sram_sck   (sram_sck),
        .sram_sio_i (sram_sio_i),
        .sram_sio_o (sram_sio_o),
        .sram_sio_oe(sram_sio_oe),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .quad_mode  (quad_mode)
    );

    always #5 clk = ~clk;

    // backing memory with a preload port used only during reset
    logic [7:0]    mem [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [7:0]    pl_dat = 8'h00;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_dat;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    // scoreboard queues
    logic [AW+7:0] exp_wr [$];
    logic [3:0]    exp_nib [$];
    logic          exp_oe = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: write strobes, strobe overlap, and sio output on each master sck rise
    logic sck_seen = 1'b0;
    always @(negedge clk) begin
        if (mem_we && mem_re) begin
            n_cmp++;
            n_bad++;
            $display("FAIL strobe_overlap: mem_we and mem_re both high at %0t", $time);
        end
        if (mem_we) begin
            if (exp_wr.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", mem_addr, mem_wdata);
            end else begin
                logic [AW+7:0] e;
                e = exp_wr.pop_front();
                chk("write_addr_data", {7'd0, mem_addr, mem_wdata}, {7'd0, e});
            end
        end
        if (sram_sck && !sck_seen) begin
            chk("sio_oe_at_rise", {31'd0, sram_sio_oe}, {31'd0, exp_oe});
            if (exp_oe) begin
                if (exp_nib.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL read_nibble: no expectation queued, got 0x%0h", sram_sio_o);
                end else begin
                    logic [3:0] en;
                    en = exp_nib.pop_front();
                    chk("read_nibble", {28'd0, sram_sio_o}, {28'd0, en});
                end
            end
        end
        sck_seen <= sram_sck;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic unit(input logic [3:0] v);
        sram_sio_i = v;
        tick(H);
        sram_sck = 1'b1;
        tick(H);
        sram_sck = 1'b0;
    endtask

    task automatic quad_byte(input logic [7:0] b);
        unit(b[7:4]);
        unit(b[3:0]);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) unit({3'b000, b[i]});
    endtask

    task automatic quad_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) unit(a[i*4 +: 4]);
    endtask

    task automatic cs_begin();
        sram_cs_n = 1'b0;
        tick(4);
    endtask

    task automatic cs_end();
        tick(2);
        sram_cs_n = 1'b1;
        sram_sio_i = 4'h0;
        tick(8);
    endtask

    initial begin
        // reset with memory preload
        tick(1);
        pl_en = 1'b1; pl_addr = 17'h00010; pl_dat = 8'hA5;
        tick(1);
        pl_addr = 17'h00011; pl_dat = 8'h3C;
        tick(1);
        pl_en = 1'b0;
        chk("rst_sio_o", {28'd0, sram_sio_o}, 32'h0);
        chk("rst_sio_oe", {31'd0, sram_sio_oe}, 32'h0);
        chk("rst_mem_addr", {15'd0, mem_addr}, 32'h0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'h0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'h0);
        chk("rst_mem_re", {31'd0, mem_re}, 32'h0);
        chk("rst_quad_mode", {31'd0, quad_mode}, 32'h0);
        reset_n = 1'b1;
        tick(5);

        // mode entry via SPI EQIO
        cs_begin(); spi_byte(8'h38); cs_end();
        chk("eqio_quad_mode", {31'd0, quad_mode}, 32'h1);

        // quad write of two bytes
        cs_begin(); quad_byte(8'h02); quad_addr(24'h000010);
        exp_wr.push_back({17'h00010, 8'hA5}); quad_byte(8'hA5);
        exp_wr.push_back({17'h00011, 8'h3C}); quad_byte(8'h3C);
        cs_end();

        // quad read with prefetch
        cs_begin(); quad_byte(8'h03); quad_addr(24'h000010);
        unit(4'h0); unit(4'h0);
        exp_oe = 1'b1;
        exp_nib.push_back(4'hA); unit(4'h0);
        exp_nib.push_back(4'h5); unit(4'h0);
        exp_nib.push_back(4'h3); unit(4'h0);
        exp_nib.push_back(4'hC); unit(4'h0);
        exp_oe = 1'b0;
        cs_end();
        chk("oe_after_cs_high", {31'd0, sram_sio_oe}, 32'h0);

        // address wrap
        cs_begin(); quad_byte(8'h02); quad_addr(24'h01FFFF);
        exp_wr.push_back({17'h1FFFF, 8'hDE}); quad_byte(8'hDE);
        exp_wr.push_back({17'h00000, 8'hAD}); quad_byte(8'hAD);
        cs_end();

        // abort after one nibble, then a clean write
        cs_begin(); quad_byte(8'h02); quad_addr(24'h000030); unit(4'h9); cs_end();
        cs_begin(); quad_byte(8'h02); quad_addr(24'h000020);
        exp_wr.push_back({17'h00020, 8'h77}); quad_byte(8'h77);
        cs_end();

        // unknown quad command is ignored along with its trailing nibbles
        cs_begin(); quad_byte(8'h05); quad_byte(8'h12); quad_byte(8'h34); cs_end();
        chk("unknown_cmd_quad_kept", {31'd0, quad_mode}, 32'h1);

        // RSTIO back to SPI, then re-enter quad
        cs_begin(); quad_byte(8'hFF); cs_end();
        chk("rstio_quad_mode", {31'd0, quad_mode}, 32'h0);
        cs_begin(); spi_byte(8'h38); cs_end();
        chk("reenter_quad_mode", {31'd0, quad_mode}, 32'h1);

        // async reset during RDATA
        cs_begin(); quad_byte(8'h03); quad_addr(24'h000010);
        unit(4'h0); unit(4'h0);
        exp_oe = 1'b1;
        exp_nib.push_back(4'hA); unit(4'h0);
        tick(4);
        chk("pre_reset_oe", {31'd0, sram_sio_oe}, 32'h1);
        reset_n = 1'b0;
        #2;
        chk("async_rst_oe", {31'd0, sram_sio_oe}, 32'h0);
        chk("async_rst_quad_mode", {31'd0, quad_mode}, 32'h0);
        chk("async_rst_sio_o", {28'd0, sram_sio_o}, 32'h0);
        chk("async_rst_mem_addr", {15'd0, mem_addr}, 32'h0);
        exp_oe = 1'b0;
        tick(2);
        sram_cs_n = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(10);

        chk("leftover_writes", exp_wr.size(), 32'd0);
        chk("leftover_nibbles", exp_nib.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
